// File: rtl/bootram_pkg.sv
// Shared definitions for the boot RAM word bridge: FSM encoding and timing constants.
package bootram_pkg;

  // Bridge FSM states. ACCESS walks one byte lane per cycle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } bootram_state_e;

  // Byte lanes per 32-bit CPU word.
  localparam int LANES = 4;

  // Cycles from request acceptance (cycle T) to the mem_ready pulse.
  localparam int READ_LAT  = 6;
  localparam int WRITE_LAT = 5;

endpackage

// File: rtl/bootram_word_bridge.sv
// Bridges a 32-bit valid/ready CPU memory port onto an 8-bit synchronous boot RAM.
// A word access is split into four byte-lane RAM cycles, lane 0 first.
//
// Handshake: the CPU raises mem_valid with address/data/strobes and holds them
// until mem_ready. mem_ready is a single-cycle pulse and is the only completion
// indication; once a request is accepted the bridge completes it regardless of
// what mem_valid does afterwards. A new request is accepted no earlier than the
// cycle after mem_ready.
module bootram_word_bridge
  import bootram_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              ram_ce,
  output logic              ram_wre,
  output logic              ram_oce,
  output logic              ram_reset,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic [1:0]        dbg_state
);

  bootram_state_e state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        lane_nx;
  logic [ADDR_W-3:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              is_write;

  logic              ram_ce_d;
  logic              ram_wre_d;
  logic [ADDR_W-1:0] ram_ad_d;
  logic [7:0]        ram_din_d;
  logic              cap_en;
  logic [1:0]        cap_lane;

  // Address bits outside the RAM word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_W], mem_addr[1:0]};

  assign is_write  = (wstrb_q != 4'b0000);
  assign lane_nx   = lane_q + 2'd1;
  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;
  assign dbg_state = state_q;

  // State register and lane counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lane_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Next-state logic: writes finish straight from lane 3, reads need one more
  // cycle to collect the last RAM byte.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          state_d = ST_ACCESS;
          lane_d  = 2'd0;
        end
      end
      ST_ACCESS: begin
        if (lane_q == 2'(LANES - 1)) begin
          state_d = is_write ? ST_DONE : ST_DRAIN;
          lane_d  = 2'd0;
        end else begin
          lane_d = lane_nx;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for the registered RAM port, read-capture control
  // and the completion pulse. The RAM port is loaded one cycle ahead of the lane
  // it serves, so lane 0 comes straight from the CPU inputs at acceptance.
  always_comb begin
    ram_ce_d  = 1'b0;
    ram_wre_d = 1'b0;
    ram_ad_d  = ram_ad;
    ram_din_d = ram_din;
    cap_en    = 1'b0;
    cap_lane  = 2'd0;
    mem_ready = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          ram_ce_d  = 1'b1;
          ram_ad_d  = {mem_addr[ADDR_W-1:2], 2'b00};
          ram_wre_d = mem_wstrb[0];
          ram_din_d = mem_wdata[7:0];
        end
      end
      ST_ACCESS: begin
        if (lane_q != 2'(LANES - 1)) begin
          ram_ce_d  = 1'b1;
          ram_ad_d  = {addr_q, lane_nx};
          ram_wre_d = wstrb_q[lane_nx];
          ram_din_d = wdata_q[{lane_nx, 3'b000} +: 8];
        end
        // The byte for lane k-1 is on ram_dout while lane k is being issued.
        if (!is_write && lane_q != 2'd0) begin
          cap_en   = 1'b1;
          cap_lane = lane_q - 2'd1;
        end
      end
      ST_DRAIN: begin
        cap_en   = 1'b1;
        cap_lane = 2'(LANES - 1);
      end
      default: ;
    endcase
  end

  // Request latch, taken at the acceptance edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state_q == ST_IDLE && mem_valid) begin
      addr_q  <= mem_addr[ADDR_W-1:2];
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
    end
  end

  // Registered RAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
      ram_ad  <= '0;
      ram_din <= '0;
    end else begin
      ram_ce  <= ram_ce_d;
      ram_wre <= ram_wre_d;
      ram_ad  <= ram_ad_d;
      ram_din <= ram_din_d;
    end
  end

  // Read word assembly; holds its value until the next read overwrites it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_rdata <= '0;
    end else if (cap_en) begin
      mem_rdata[{cap_lane, 3'b000} +: 8] <= ram_dout;
    end
  end

endmodule

// File: tb/tb_bootram_word_bridge.sv
// Directed bench for bootram_word_bridge with a behavioural 2Kx8 RAM model.
module tb_bootram_word_bridge;
  import bootram_pkg::*;

  localparam int ADDR_W = 11;

  logic              clk;
  logic              reset;
  logic              mem_valid;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              ram_ce;
  logic              ram_wre;
  logic              ram_oce;
  logic              ram_reset;
  logic [ADDR_W-1:0] ram_ad;
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [1:0]        dbg_state;

  int checks;
  int errors;

  // Per-transaction observation log, indexed by cycle offset from T.
  logic              ce_log  [0:31];
  logic              wre_log [0:31];
  logic [ADDR_W-1:0] ad_log  [0:31];
  logic [7:0]        din_log [0:31];
  int                rdy_at  [0:3];
  logic [31:0]       rd_at   [0:3];
  int                rdy_cnt;

  logic [7:0] ram_mem [0:(1<<ADDR_W)-1];

  bootram_word_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ram_ce    (ram_ce),
    .ram_wre   (ram_wre),
    .ram_oce   (ram_oce),
    .ram_reset (ram_reset),
    .ram_ad    (ram_ad),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM model, read-before-write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_dout <= ram_mem[ram_ad];
      if (ram_wre) ram_mem[ram_ad] <= ram_din;
    end
  end

  // Run one request starting at cycle T; observe cycles T+1..T+ncyc at negedges.
  // mem_valid is dropped at cycle drop_cycle (0 = never early) or once
  // stop_after ready pulses have been seen.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int drop_cycle,
                         input int stop_after, input int ncyc);
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rdy_at[i] = -1;
      rd_at[i]  = 32'hx;
    end
    for (int i = 0; i < 32; i++) begin
      ce_log[i] = 1'b0; wre_log[i] = 1'b0; ad_log[i] = '0; din_log[i] = '0;
    end
    @(negedge clk);
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    mem_valid = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      ce_log[n]  = ram_ce;
      wre_log[n] = ram_wre;
      ad_log[n]  = ram_ad;
      din_log[n] = ram_din;
      if (mem_ready) begin
        if (rdy_cnt < 4) begin
          rdy_at[rdy_cnt] = n;
          rd_at[rdy_cnt]  = mem_rdata;
        end
        rdy_cnt++;
        if (rdy_cnt >= stop_after) mem_valid = 1'b0;
      end
      if (n == drop_cycle) mem_valid = 1'b0;
    end
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", mem_ready); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 00000000", mem_rdata); end
    checks++; if ({ram_ce, ram_wre} !== 2'b00) begin errors++; $display("FAIL reset_ce_wre got %b want 00", {ram_ce, ram_wre}); end
    checks++; if (ram_ad !== 11'h0 || ram_din !== 8'h0) begin errors++; $display("FAIL reset_ad_din got %h/%h want 000/00", ram_ad, ram_din); end
    checks++; if ({ram_oce, ram_reset} !== 2'b10) begin errors++; $display("FAIL ties got oce=%b reset=%b want 1/0", ram_oce, ram_reset); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_write_read();
    logic [7:0] exp_b [0:3];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    run_txn(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 1, 10);
    checks++; if (rdy_at[0] !== WRITE_LAT || rdy_cnt !== 1) begin errors++; $display("FAIL wr_full_ready at %0d cnt %0d want 5/1", rdy_at[0], rdy_cnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ce_log[k+1] !== 1'b1 || wre_log[k+1] !== 1'b1 || ad_log[k+1] !== 11'(16 + k) || din_log[k+1] !== exp_b[k]) begin
        errors++; $display("FAIL wr_full_lane%0d got ce=%b wre=%b ad=%h din=%h want 1/1/%h/%h", k, ce_log[k+1], wre_log[k+1], ad_log[k+1], din_log[k+1], 11'(16 + k), exp_b[k]);
      end
      checks++; if (ram_mem[16 + k] !== exp_b[k]) begin errors++; $display("FAIL wr_full_ram%0d got %h want %h", k, ram_mem[16 + k], exp_b[k]); end
    end
    checks++; if (ce_log[5] !== 1'b0) begin errors++; $display("FAIL wr_full_ce_done got %b want 0", ce_log[5]); end
    run_txn(32'h0000_0010, 32'h0, 4'b0000, 0, 1, 10);
    checks++; if (rdy_at[0] !== READ_LAT || rdy_cnt !== 1) begin errors++; $display("FAIL rd_full_ready at %0d cnt %0d want 6/1", rdy_at[0], rdy_cnt); end
    checks++; if (rd_at[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_full_data got %h want deadbeef", rd_at[0]); end
    checks++; if (mem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_full_hold got %h want deadbeef", mem_rdata); end
    checks++; if ({wre_log[1], wre_log[2], wre_log[3], wre_log[4]} !== 4'b0000) begin errors++; $display("FAIL rd_full_wre got %b want 0000", {wre_log[1], wre_log[2], wre_log[3], wre_log[4]}); end
  endtask

  task automatic test_partial_write();
    run_txn(32'h0000_0010, 32'h00AA_0000, 4'b0100, 0, 1, 10);
    checks++; if (rdy_at[0] !== 5) begin errors++; $display("FAIL wr_part_ready at %0d want 5", rdy_at[0]); end
    checks++;
    if ({wre_log[4], wre_log[3], wre_log[2], wre_log[1]} !== 4'b0100) begin
      errors++; $display("FAIL wr_part_wre got %b want 0100", {wre_log[4], wre_log[3], wre_log[2], wre_log[1]});
    end
    checks++; if (ce_log[1] !== 1'b1 || ce_log[4] !== 1'b1 || din_log[3] !== 8'hAA) begin errors++; $display("FAIL wr_part_lane got ce1=%b ce4=%b din2=%h want 1/1/aa", ce_log[1], ce_log[4], din_log[3]); end
    run_txn(32'h0000_0010, 32'h0, 4'b0000, 0, 1, 10);
    checks++; if (rd_at[0] !== 32'hDEAA_BEEF || rdy_at[0] !== 6) begin errors++; $display("FAIL rd_part got %h at %0d want deaabeef at 6", rd_at[0], rdy_at[0]); end
  endtask

  task automatic test_alias();
    run_txn(32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 0, 1, 8);
    run_txn(32'h0000_07FC, 32'h1122_3344, 4'b1111, 0, 1, 8);
    checks++; if (ad_log[1] !== 11'h7FC || ad_log[4] !== 11'h7FF) begin errors++; $display("FAIL alias_wr_ad got %h..%h want 7fc..7ff", ad_log[1], ad_log[4]); end
    run_txn(32'h0000_07FC, 32'h0, 4'b0000, 0, 1, 8);
    checks++; if (rd_at[0] !== 32'h1122_3344) begin errors++; $display("FAIL alias_rd_7fc got %h want 11223344", rd_at[0]); end
    run_txn(32'h0000_0800, 32'h0, 4'b0000, 0, 1, 8);
    for (int k = 0; k < 4; k++) begin
      checks++; if (ad_log[k+1] !== 11'(k)) begin errors++; $display("FAIL alias_ad%0d got %h want %h", k, ad_log[k+1], 11'(k)); end
    end
    checks++; if (rd_at[0] !== 32'hCAFE_F00D) begin errors++; $display("FAIL alias_rd_800 got %h want cafef00d", rd_at[0]); end
  endtask

  task automatic test_reset_midread();
    int extra_rdy;
    extra_rdy = 0;
    @(negedge clk);
    mem_addr = 32'h0000_0010; mem_wstrb = 4'b0000; mem_valid = 1'b1;
    repeat (3) @(negedge clk);   // now in cycle T+3
    reset = 1'b1;
    mem_valid = 1'b0;
    #1;
    checks++;
    if ({mem_ready, ram_ce, ram_wre} !== 3'b000 || ram_ad !== 11'h0 || ram_din !== 8'h0 || mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs got rdy=%b ce=%b wre=%b ad=%h din=%h rdata=%h want all 0", mem_ready, ram_ce, ram_wre, ram_ad, ram_din, mem_rdata);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mem_ready) extra_rdy++;
    end
    checks++; if (extra_rdy !== 0) begin errors++; $display("FAIL rst_mid_no_ready got %0d pulses want 0", extra_rdy); end
    run_txn(32'h0000_0010, 32'h0, 4'b0000, 0, 1, 10);
    checks++; if (rd_at[0] !== 32'hDEAA_BEEF || rdy_at[0] !== 6) begin errors++; $display("FAIL rst_mid_after got %h at %0d want deaabeef at 6", rd_at[0], rdy_at[0]); end
  endtask

  task automatic test_back_to_back();
    run_txn(32'h0000_07FC, 32'h0, 4'b0000, 0, 2, 16);
    checks++; if (rdy_at[0] !== 6 || rdy_at[1] !== 13) begin errors++; $display("FAIL b2b_ready_at got %0d,%0d want 6,13", rdy_at[0], rdy_at[1]); end
    checks++; if (rdy_cnt !== 2) begin errors++; $display("FAIL b2b_ready_cnt got %0d want 2", rdy_cnt); end
    checks++; if (ce_log[7] !== 1'b0 || ce_log[8] !== 1'b1 || ad_log[8] !== 11'h7FC) begin errors++; $display("FAIL b2b_second_issue got ce7=%b ce8=%b ad8=%h want 0/1/7fc", ce_log[7], ce_log[8], ad_log[8]); end
    checks++; if (rd_at[1] !== 32'h1122_3344) begin errors++; $display("FAIL b2b_data got %h want 11223344", rd_at[1]); end
  endtask

  task automatic test_drop_valid();
    run_txn(32'h0000_0020, 32'h5566_7788, 4'b1111, 2, 1, 10);
    checks++; if ({ce_log[1], ce_log[2], ce_log[3], ce_log[4]} !== 4'b1111) begin errors++; $display("FAIL drop_lanes got %b want 1111", {ce_log[1], ce_log[2], ce_log[3], ce_log[4]}); end
    checks++; if (rdy_at[0] !== 5 || rdy_cnt !== 1) begin errors++; $display("FAIL drop_ready at %0d cnt %0d want 5/1", rdy_at[0], rdy_cnt); end
    checks++;
    if ({ram_mem[35], ram_mem[34], ram_mem[33], ram_mem[32]} !== 32'h5566_7788) begin
      errors++; $display("FAIL drop_ram got %h want 55667788", {ram_mem[35], ram_mem[34], ram_mem[33], ram_mem[32]});
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = 8'h00;
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_alias();
    test_reset_midread();
    test_back_to_back();
    test_drop_valid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bootram_word_bridge.md
BOOTRAM_WORD_BRIDGE -- requirements
Module: bootram_word_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, the byte-address width of the attached 8-bit boot RAM.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port mem_valid, input, 1, CPU request valid; held high until mem_ready.
REQ-005 SHALL have port mem_addr, input, 32, CPU byte address; only bits [ADDR_W-1:2] are used.
REQ-006 SHALL have port mem_wdata, input, 32, write data, little-endian lanes.
REQ-007 SHALL have port mem_wstrb, input, 4, byte write strobes; 4'b0000 means read.
REQ-008 SHALL have port mem_ready, output, 1, one-cycle transaction-complete pulse.
REQ-009 SHALL have port mem_rdata, output, 32, assembled read word.
REQ-010 SHALL have ports ram_ce, ram_wre, ram_oce, ram_reset (output, 1 each), ram_ad (output, ADDR_W) and ram_din (output, 8), driving the RAM port of the same names.
REQ-011 SHALL have port ram_dout, input, 8, RAM read data, valid in the cycle after the clock edge that samples ram_ad with ram_ce=1.

Function
REQ-012 SHALL implement states IDLE, ACCESS (lane counter 0..3), DRAIN and DONE.
REQ-013 SHALL move from IDLE to ACCESS when mem_valid=1 is sampled in cycle T, and latch mem_addr, mem_wdata and mem_wstrb at that edge.
REQ-014 SHALL drive ram_ce=1 and ram_ad={latched addr[ADDR_W-1:2], k[1:0]} in cycles T+1..T+4 for lanes k=0..3, with all RAM outputs registered.
REQ-015 SHALL, for a write, drive ram_wre=wstrb[k] and ram_din=wdata[8k+7:8k] in lane k's cycle; lanes with a clear strobe SHALL be idle cycles with ram_wre=0.
REQ-016 SHALL complete a write by pulsing mem_ready in cycle T+5, skipping DRAIN.
REQ-017 SHALL, for a read, capture ram_dout into mem_rdata[8k+7:8k] at the end of cycle T+2+k, enter DRAIN after lane 3, and pulse mem_ready in cycle T+6.
REQ-018 SHALL hold mem_rdata stable from the mem_ready cycle until the next read capture; mem_rdata content during writes is don't-care.
REQ-019 SHALL return to IDLE after DONE; the earliest next request acceptance is the cycle after mem_ready.
REQ-020 SHALL finish a started transaction, including its mem_ready pulse, even if mem_valid drops mid-transaction.
REQ-021 SHALL ignore address bits at and above ADDR_W, so addresses alias modulo 2^ADDR_W, and SHALL not increment across the word (lane k only replaces bits [1:0]).
REQ-022 SHALL tie ram_oce=1 and ram_reset=0; ram_ce=0 and ram_wre=0 in IDLE, DRAIN and DONE.

Reset
REQ-023 SHALL on reset immediately force the state to IDLE, the lane counter to 0, mem_ready=0, mem_rdata=0, ram_ce=0, ram_wre=0, ram_ad=0 and ram_din=0.
REQ-024 SHALL abandon an in-flight transaction on reset without issuing mem_ready; bytes already written remain written.

Structure
REQ-025 SHALL take the state encoding and the constants LANES=4 and READ_LAT=6/WRITE_LAT=5 from a shared package bootram_pkg.
REQ-026 SHALL be a single module with no sub-modules; a behavioural 2Kx8 RAM model with a 1-cycle read is bench-only.

Verification
REQ-027 Write 0xDEADBEEF with wstrb=1111 to 0x010 and then read 0x010 -> write ready at T+5; read ready at T+6 with rdata=0xDEADBEEF; RAM bytes 0x010..0x013 = EF,BE,AD,DE.
REQ-028 Partial write with wdata=0x00AA0000 and wstrb=0100 to 0x010, then read -> 0xDEAABEEF; ram_wre high only in lane-2 cycle.
REQ-029 Write 0x11223344 to 0x7FC, then read 0x7FC and 0x800 -> read of 0x7FC returns 0x11223344; 0x800 aliases 0x000, so ram_ad goes 0x000..0x003.
REQ-030 Assert reset in cycle T+3 of a read -> all outputs go to 0 asynchronously and no mem_ready follows; a read after reset release completes normally at T+6.
REQ-031 Issue back-to-back reads with mem_valid held high -> the second is accepted the cycle after the first mem_ready, with exactly one mem_ready per transaction.
REQ-032 Drop mem_valid at T+2 of a write -> all four lanes are still issued and mem_ready pulses at T+5.
